postproc_pipeline: RTL and testbench

Parametrised output post-processing pipeline for the CPS2 digital AV path. It converts line-buffer pixel data (n-bit RGB plus fade code) into full-depth RGB and applies fade, horizontal/vertical/combined scanlines and a windowed border mask. Line and column phase are derived internally from the sync and DE inputs. All configuration is shadowed and takes effect only at the frame boundary. It sits between the line-buffer read port and the video transmitter, on the output pixel clock.

---
 rtl/postproc_pipeline_if.sv | 23 ++
 rtl/postproc_pipeline.sv | 228 ++++++++++++++++++++++
 tb/tb_postproc_pipeline.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/postproc_pipeline_if.sv
// Pixel bus for the post-processing pipeline: line-buffer side in, transmitter side out.
interface postproc_pipeline_if #(
  parameter int IN_BITS   = 4,
  parameter int FADE_BITS = 4,
  parameter int OUT_BITS  = 8,
  parameter int CNT_W     = 11
);
  logic [IN_BITS-1:0]   R_in, G_in, B_in;
  logic [FADE_BITS-1:0] F_in;
  logic                 HSYNC_in, VSYNC_in, DE_in;
  logic [CNT_W-1:0]     hcnt_in, vcnt_in;
  logic [OUT_BITS-1:0]  R_out, G_out, B_out;
  logic                 HSYNC_out, VSYNC_out, DE_out;

  modport master (
    output R_in, G_in, B_in, F_in, HSYNC_in, VSYNC_in, DE_in, hcnt_in, vcnt_in,
    input  R_out, G_out, B_out, HSYNC_out, VSYNC_out, DE_out
  );
  modport slave (
    input  R_in, G_in, B_in, F_in, HSYNC_in, VSYNC_in, DE_in, hcnt_in, vcnt_in,
    output R_out, G_out, B_out, HSYNC_out, VSYNC_out, DE_out
  );
endinterface

// File: rtl/postproc_pipeline.sv
// Output post-processing: expand/fade, scanlines, border mask. Fixed 4-cycle latency.
// Per-channel datapath (S1..S4) lives in postproc_chan; shared control rides alongside.
module postproc_chan #(
  parameter int IN_BITS   = 4,
  parameter int FADE_BITS = 4,
  parameter int OUT_BITS  = 8
) (
  input  logic                 PCLK,
  input  logic                 reset,
  input  logic [IN_BITS-1:0]   d_in,
  input  logic                 s1_fade,
  input  logic [FADE_BITS-1:0] s1_f,
  input  logic                 s2_dark,
  input  logic [OUT_BITS-1:0]  s2_str,
  input  logic                 s3_hit,
  input  logic [3:0]           s3_br,
  output logic [OUT_BITS-1:0]  q
);
  localparam int PW = OUT_BITS + 1;

  logic [IN_BITS-1:0]  d1;
  logic [OUT_BITS-1:0] d2, d3, rep, expd, mask_px;
  logic [PW-1:0]       fmul, prod;

  // Bit replication fills the full output range (0xA -> 0xAA); fade is d*(F+2) saturated
  always_comb begin
    rep = '0;
    for (int i = 0; i < OUT_BITS; i++)
      rep[OUT_BITS-1-i] = d1[IN_BITS-1-(i % IN_BITS)];
    fmul    = PW'(s1_f) + PW'(2);
    prod    = PW'(d1) * fmul;
    expd    = s1_fade ? (prod[OUT_BITS] ? '1 : prod[OUT_BITS-1:0]) : rep;
    mask_px = OUT_BITS'(s3_br) << (OUT_BITS - 4);
  end

  // S1 capture, S2 expand, S3 scanline subtract (floor at 0), S4 mask
  always_ff @(posedge PCLK) begin
    if (reset) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
      q  <= '0;
    end else begin
      d1 <= d_in;
      d2 <= expd;
      d3 <= s2_dark ? ((d2 > s2_str) ? d2 - s2_str : '0) : d2;
      q  <= s3_hit ? mask_px : d3;
    end
  end
endmodule

module postproc_pipeline #(
  parameter int IN_BITS   = 4,
  parameter int FADE_BITS = 4,
  parameter int OUT_BITS  = 8,
  parameter int CNT_W     = 11
) (
  input  logic              PCLK,
  input  logic              reset,
  postproc_pipeline_if.slave px,
  input  logic              cfg_fade_en,
  input  logic [1:0]        cfg_sl_mode,
  input  logic [3:0]        cfg_sl_str,
  input  logic [4:0]        cfg_sl_id,
  input  logic [2:0]        cfg_vmult,
  input  logic [2:0]        cfg_hmult,
  input  logic              cfg_mask_en,
  input  logic [CNT_W-1:0]  cfg_mask_hstart,
  input  logic [CNT_W-1:0]  cfg_mask_hstop,
  input  logic [CNT_W-1:0]  cfg_mask_vstart,
  input  logic [CNT_W-1:0]  cfg_mask_vstop,
  input  logic [3:0]        cfg_mask_br,
  output logic              cfg_update
);
  localparam int STAGES = 4;
  localparam int NUM_LANES = 3;

  // shadow configuration, loaded only at the VSYNC leading edge
  logic             sh_fade, sh_mask_en;
  logic [1:0]       sh_mode;
  logic [3:0]       sh_str, sh_br;
  logic [4:0]       sh_sl_id;
  logic [2:0]       sh_vmult, sh_hmult;
  logic [CNT_W-1:0] sh_hstart, sh_hstop, sh_vstart, sh_vstop;

  logic       hs_prev, vs_prev, hs_edge, vs_edge;
  logic [2:0] line_id, col_id, eff_vmult, eff_hmult;
  logic [7:0] sl_id_ext;
  logic       dark_c, hit_c;
  logic [OUT_BITS-1:0] str_c;

  // per-pixel control carried down the pipe so a config swap never splits a pixel
  logic                 s1_fade, s1_dark, s1_hit, s2_dark, s2_hit, s3_hit;
  logic [FADE_BITS-1:0] s1_f;
  logic [OUT_BITS-1:0]  s1_str, s2_str;
  logic [3:0]           s1_br, s2_br, s3_br;
  logic [STAGES:1]      hs_pipe, vs_pipe, vld_pipe;

  logic [NUM_LANES-1:0][IN_BITS-1:0]  rgb_in;
  logic [NUM_LANES-1:0][OUT_BITS-1:0] rgb_out;

  // edges, effective multipliers, darken decision and window test for the incoming pixel
  always_comb begin
    hs_edge   = hs_prev & ~px.HSYNC_in;
    vs_edge   = vs_prev & ~px.VSYNC_in;
    eff_vmult = (sh_vmult == 3'd0) ? 3'd1 : sh_vmult;
    eff_hmult = (sh_hmult == 3'd0) ? 3'd1 : sh_hmult;
    sl_id_ext = {3'b000, sh_sl_id};
    dark_c    = (sh_mode[0] && sl_id_ext[line_id]) || (sh_mode[1] && (col_id == 3'd0));
    str_c     = (OUT_BITS'(sh_str) << (OUT_BITS - 4)) | OUT_BITS'((1 << (OUT_BITS - 4)) - 1);
    hit_c     = sh_mask_en && ((px.hcnt_in < sh_hstart) || (px.hcnt_in >= sh_hstop) ||
                               (px.vcnt_in < sh_vstart) || (px.vcnt_in >= sh_vstop));
  end

  // sync history, shadow load and cfg_update pulse
  always_ff @(posedge PCLK) begin
    if (reset) begin
      hs_prev    <= 1'b1;
      vs_prev    <= 1'b1;
      cfg_update <= 1'b0;
      sh_fade    <= 1'b0;
      sh_mode    <= '0;
      sh_str     <= '0;
      sh_sl_id   <= '0;
      sh_vmult   <= '0;
      sh_hmult   <= '0;
      sh_mask_en <= 1'b0;
      sh_hstart  <= '0;
      sh_hstop   <= '0;
      sh_vstart  <= '0;
      sh_vstop   <= '0;
      sh_br      <= '0;
    end else begin
      hs_prev    <= px.HSYNC_in;
      vs_prev    <= px.VSYNC_in;
      cfg_update <= vs_edge;
      if (vs_edge) begin
        sh_fade    <= cfg_fade_en;
        sh_mode    <= cfg_sl_mode;
        sh_str     <= cfg_sl_str;
        sh_sl_id   <= cfg_sl_id;
        sh_vmult   <= cfg_vmult;
        sh_hmult   <= cfg_hmult;
        sh_mask_en <= cfg_mask_en;
        sh_hstart  <= cfg_mask_hstart;
        sh_hstop   <= cfg_mask_hstop;
        sh_vstart  <= cfg_mask_vstart;
        sh_vstop   <= cfg_mask_vstop;
        sh_br      <= cfg_mask_br;
      end
    end
  end

  // line/column phase; VSYNC takes priority over a coincident HSYNC
  always_ff @(posedge PCLK) begin
    if (reset) begin
      line_id <= '0;
      col_id  <= '0;
    end else begin
      if (vs_edge)
        line_id <= '0;
      else if (hs_edge)
        line_id <= (line_id >= eff_vmult - 3'd1) ? 3'd0 : line_id + 3'd1;
      if (!px.DE_in)
        col_id <= '0;
      else
        col_id <= (col_id >= eff_hmult - 3'd1) ? 3'd0 : col_id + 3'd1;
    end
  end

  // control and sync pipeline, kept in lockstep with the channel datapath
  always_ff @(posedge PCLK) begin
    if (reset) begin
      s1_fade  <= 1'b0;
      s1_f     <= '0;
      s1_dark  <= 1'b0;
      s1_str   <= '0;
      s1_hit   <= 1'b0;
      s1_br    <= '0;
      s2_dark  <= 1'b0;
      s2_str   <= '0;
      s2_hit   <= 1'b0;
      s2_br    <= '0;
      s3_hit   <= 1'b0;
      s3_br    <= '0;
      hs_pipe  <= '1;
      vs_pipe  <= '1;
      vld_pipe <= '0;
    end else begin
      s1_fade  <= sh_fade;
      s1_f     <= px.F_in;
      s1_dark  <= dark_c;
      s1_str   <= str_c;
      s1_hit   <= hit_c;
      s1_br    <= sh_br;
      s2_dark  <= s1_dark;
      s2_str   <= s1_str;
      s2_hit   <= s1_hit;
      s2_br    <= s1_br;
      s3_hit   <= s2_hit;
      s3_br    <= s2_br;
      hs_pipe  <= {hs_pipe[STAGES-1:1], px.HSYNC_in};
      vs_pipe  <= {vs_pipe[STAGES-1:1], px.VSYNC_in};
      vld_pipe <= {vld_pipe[STAGES-1:1], px.DE_in};
    end
  end

  assign rgb_in = {px.R_in, px.G_in, px.B_in};

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    postproc_chan #(
      .IN_BITS(IN_BITS), .FADE_BITS(FADE_BITS), .OUT_BITS(OUT_BITS)
    ) u_chan (
      .PCLK(PCLK), .reset(reset), .d_in(rgb_in[l]),
      .s1_fade(s1_fade), .s1_f(s1_f),
      .s2_dark(s2_dark), .s2_str(s2_str),
      .s3_hit(s3_hit), .s3_br(s3_br),
      .q(rgb_out[l])
    );
  end

  assign px.R_out     = rgb_out[2];
  assign px.G_out     = rgb_out[1];
  assign px.B_out     = rgb_out[0];
  assign px.HSYNC_out = hs_pipe[STAGES];
  assign px.VSYNC_out = vs_pipe[STAGES];
  assign px.DE_out    = vld_pipe[STAGES];
endmodule

// File: tb/tb_postproc_pipeline.sv
// Directed bench: each px() call is one pixel; its expectation is checked 4 cycles later.
module tb_postproc_pipeline;
  logic        PCLK = 1'b0;
  logic        reset;
  logic        cfg_fade_en, cfg_mask_en, cfg_update;
  logic [1:0]  cfg_sl_mode;
  logic [3:0]  cfg_sl_str, cfg_mask_br;
  logic [4:0]  cfg_sl_id;
  logic [2:0]  cfg_vmult, cfg_hmult;
  logic [10:0] cfg_mask_hstart, cfg_mask_hstop, cfg_mask_vstart, cfg_mask_vstop;
  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic       c;
    logic [7:0] r, g, b;
    logic       hs, vs, de;
  } exp_t;
  exp_t expq[$];

  postproc_pipeline_if vif();

  postproc_pipeline dut (
    .PCLK(PCLK), .reset(reset), .px(vif),
    .cfg_fade_en(cfg_fade_en), .cfg_sl_mode(cfg_sl_mode), .cfg_sl_str(cfg_sl_str),
    .cfg_sl_id(cfg_sl_id), .cfg_vmult(cfg_vmult), .cfg_hmult(cfg_hmult),
    .cfg_mask_en(cfg_mask_en), .cfg_mask_hstart(cfg_mask_hstart),
    .cfg_mask_hstop(cfg_mask_hstop), .cfg_mask_vstart(cfg_mask_vstart),
    .cfg_mask_vstop(cfg_mask_vstop), .cfg_mask_br(cfg_mask_br),
    .cfg_update(cfg_update)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic px(input logic [3:0] r, g, b, f, input logic hs, vs, de,
                    input logic [10:0] hc, vc, input logic c,
                    input logic [7:0] er, eg, eb);
    exp_t e, o;
    vif.R_in = r; vif.G_in = g; vif.B_in = b; vif.F_in = f;
    vif.HSYNC_in = hs; vif.VSYNC_in = vs; vif.DE_in = de;
    vif.hcnt_in = hc; vif.vcnt_in = vc;
    e.c = c; e.r = er; e.g = eg; e.b = eb; e.hs = hs; e.vs = vs; e.de = de;
    expq.push_back(e);
    @(posedge PCLK); #1;
    if (expq.size() == 4) begin
      o = expq.pop_front();
      chk("hsync_out", {31'd0, vif.HSYNC_out}, {31'd0, o.hs});
      chk("vsync_out", {31'd0, vif.VSYNC_out}, {31'd0, o.vs});
      chk("de_out",    {31'd0, vif.DE_out},    {31'd0, o.de});
      if (o.c) begin
        chk("r_out", {24'd0, vif.R_out}, {24'd0, o.r});
        chk("g_out", {24'd0, vif.G_out}, {24'd0, o.g});
        chk("b_out", {24'd0, vif.B_out}, {24'd0, o.b});
      end
    end
  endtask

  task automatic pix(input logic [3:0] r, g, b, f, input logic [10:0] hc,
                     input logic [7:0] er, eg, eb);
    px(r, g, b, f, 1'b1, 1'b1, 1'b1, hc, 11'd50, 1'b1, er, eg, eb);
  endtask

  task automatic blank(input logic hs, vs);
    px(4'd0, 4'd0, 4'd0, 4'd0, hs, vs, 1'b0, 11'd0, 11'd0, 1'b0, 8'd0, 8'd0, 8'd0);
  endtask

  task automatic vs_load;
    blank(1'b1, 1'b0);
    chk("cfg_update_set", {31'd0, cfg_update}, 32'd1);
    blank(1'b1, 1'b1);
    chk("cfg_update_clr", {31'd0, cfg_update}, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_r"},  {24'd0, vif.R_out}, 32'd0);
    chk({tag, "_g"},  {24'd0, vif.G_out}, 32'd0);
    chk({tag, "_b"},  {24'd0, vif.B_out}, 32'd0);
    chk({tag, "_hs"}, {31'd0, vif.HSYNC_out}, 32'd1);
    chk({tag, "_vs"}, {31'd0, vif.VSYNC_out}, 32'd1);
    chk({tag, "_de"}, {31'd0, vif.DE_out}, 32'd0);
    chk({tag, "_upd"}, {31'd0, cfg_update}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    cfg_fade_en = 0; cfg_sl_mode = 0; cfg_sl_str = 0; cfg_sl_id = 0;
    cfg_vmult = 0; cfg_hmult = 0; cfg_mask_en = 0; cfg_mask_br = 0;
    cfg_mask_hstart = 0; cfg_mask_hstop = 0; cfg_mask_vstart = 0; cfg_mask_vstop = 0;
    vif.R_in = 0; vif.G_in = 0; vif.B_in = 0; vif.F_in = 0;
    vif.HSYNC_in = 1; vif.VSYNC_in = 1; vif.DE_in = 0; vif.hcnt_in = 0; vif.vcnt_in = 0;
    repeat (2) @(posedge PCLK);
    #1;
    check_reset_state("rst");
    reset = 1'b0;

    // pass-through with default shadow config; sync/DE delay exercised by blanks
    pix(4'hA, 4'h5, 4'h0, 4'h0, 11'd15, 8'hAA, 8'h55, 8'h00);
    pix(4'hF, 4'h1, 4'h8, 4'h7, 11'd15, 8'hFF, 8'h11, 8'h88);
    blank(1'b0, 1'b1);
    blank(1'b1, 1'b0);
    blank(1'b1, 1'b1);
    pix(4'h3, 4'hC, 4'h6, 4'h0, 11'd15, 8'h33, 8'hCC, 8'h66);

    // fade
    cfg_fade_en = 1;
    vs_load;
    pix(4'hF, 4'h3, 4'h1, 4'hF, 11'd15, 8'hFF, 8'h33, 8'h11);
    pix(4'h3, 4'h0, 4'hF, 4'h0, 11'd15, 8'h06, 8'h00, 8'h1E);
    pix(4'hF, 4'h8, 4'h1, 4'hE, 11'd15, 8'hF0, 8'h80, 8'h10);

    // horizontal scanlines, vmult 2, line 1 darkened by 127
    cfg_fade_en = 0; cfg_sl_mode = 2'd1; cfg_sl_str = 4'd7; cfg_sl_id = 5'b00010; cfg_vmult = 3'd2;
    vs_load;
    pix(4'hF, 4'h0, 4'h8, 4'h0, 11'd15, 8'hFF, 8'h00, 8'h88);
    blank(1'b0, 1'b1); blank(1'b1, 1'b1);
    pix(4'hF, 4'h0, 4'h8, 4'h0, 11'd15, 8'h80, 8'h00, 8'h09);
    blank(1'b0, 1'b1); blank(1'b1, 1'b1);
    pix(4'hF, 4'h0, 4'h8, 4'h0, 11'd15, 8'hFF, 8'h00, 8'h88);
    blank(1'b0, 1'b1); blank(1'b1, 1'b1);
    pix(4'hF, 4'h0, 4'h8, 4'h0, 11'd15, 8'h80, 8'h00, 8'h09);
    blank(1'b0, 1'b1); blank(1'b1, 1'b1);
    // coincident VSYNC+HSYNC from line 0: VSYNC wins, phase stays 0
    blank(1'b0, 1'b0);
    chk("cfg_update_coinc", {31'd0, cfg_update}, 32'd1);
    blank(1'b1, 1'b1);
    pix(4'hF, 4'h0, 4'h8, 4'h0, 11'd15, 8'hFF, 8'h00, 8'h88);

    // mode 3: sl_id bit 0 set darkens everything at vmult 1
    cfg_sl_mode = 2'd3; cfg_sl_str = 4'd15; cfg_sl_id = 5'b00001; cfg_vmult = 3'd1; cfg_hmult = 3'd3;
    vs_load;
    pix(4'hF, 4'h1, 4'h0, 4'h0, 11'd15, 8'h00, 8'h00, 8'h00);
    pix(4'hF, 4'h1, 4'h0, 4'h0, 11'd15, 8'h00, 8'h00, 8'h00);
    pix(4'hF, 4'h1, 4'h0, 4'h0, 11'd15, 8'h00, 8'h00, 8'h00);
    // only col_id 0 of each 3-pixel group
    cfg_sl_id = 5'b00000;
    vs_load;
    pix(4'hF, 4'h1, 4'h8, 4'h0, 11'd15, 8'h00, 8'h00, 8'h00);
    pix(4'hF, 4'h1, 4'h8, 4'h0, 11'd15, 8'hFF, 8'h11, 8'h88);
    pix(4'hF, 4'h1, 4'h8, 4'h0, 11'd15, 8'hFF, 8'h11, 8'h88);
    pix(4'hF, 4'h1, 4'h8, 4'h0, 11'd15, 8'h00, 8'h00, 8'h00);

    // shadow timing of the border mask
    cfg_sl_mode = 0; cfg_sl_str = 0; cfg_vmult = 0; cfg_hmult = 0;
    cfg_mask_hstart = 11'd10; cfg_mask_hstop = 11'd20;
    cfg_mask_vstart = 11'd0;  cfg_mask_vstop = 11'd100; cfg_mask_br = 4'd5;
    vs_load;
    pix(4'hA, 4'h5, 4'h0, 4'h0, 11'd5, 8'hAA, 8'h55, 8'h00);
    cfg_mask_en = 1;
    pix(4'hA, 4'h5, 4'h0, 4'h0, 11'd5, 8'hAA, 8'h55, 8'h00);
    px(4'hA, 4'h5, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 11'd5, 11'd50, 1'b1, 8'hAA, 8'h55, 8'h00);
    chk("cfg_update_mask", {31'd0, cfg_update}, 32'd1);
    pix(4'hA, 4'h5, 4'h0, 4'h0, 11'd5,  8'h50, 8'h50, 8'h50);
    chk("cfg_update_once", {31'd0, cfg_update}, 32'd0);
    pix(4'hA, 4'h5, 4'h0, 4'h0, 11'd10, 8'hAA, 8'h55, 8'h00);
    pix(4'hA, 4'h5, 4'h0, 4'h0, 11'd19, 8'hAA, 8'h55, 8'h00);
    pix(4'hA, 4'h5, 4'h0, 4'h0, 11'd20, 8'h50, 8'h50, 8'h50);
    px(4'hA, 4'h5, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 11'd15, 11'd100, 1'b1, 8'h50, 8'h50, 8'h50);
    px(4'hA, 4'h5, 4'h0, 4'h0, 1'b1, 1'b1, 1'b1, 11'd15, 11'd0,   1'b1, 8'hAA, 8'h55, 8'h00);
    px(4'hA, 4'h5, 4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 11'd5,  11'd50,  1'b1, 8'h50, 8'h50, 8'h50);
    pix(4'hA, 4'h5, 4'h0, 4'h0, 11'd5, 8'h50, 8'h50, 8'h50);
    pix(4'hA, 4'h5, 4'h0, 4'h0, 11'd5, 8'h50, 8'h50, 8'h50);

    // one-cycle reset during DE: outputs clear, shadow mask reverts to off
    vif.R_in = 4'hA; vif.DE_in = 1; vif.HSYNC_in = 1; vif.VSYNC_in = 1; vif.hcnt_in = 11'd5;
    reset = 1'b1;
    @(posedge PCLK); #1;
    check_reset_state("midrst");
    reset = 1'b0;
    expq.delete();
    pix(4'hA, 4'h5, 4'h0, 4'h0, 11'd5, 8'hAA, 8'h55, 8'h00);
    pix(4'h5, 4'hA, 4'hF, 4'h0, 11'd5, 8'h55, 8'hAA, 8'hFF);
    repeat (4) blank(1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
